cntr_incr_arbiter: RTL and testbench

Arbitrates counter-increment requests from the scaler (FS/F-stage pulses, e.g. F02A/F02B/FS02-derived TIME1–TIME6 ticks) onto the single counter-increment slot of the memory-cycle sequencer. It edge-detects each requester and holds it pending until served. Once per memory cycle (12 timepulses) it grants the highest-priority pending requester, then holds the slot for one full memory cycle. It sits between the A1 scaler outputs and the sequence generator's counter-cycle input.

---
 rtl/agc_timing_pkg.sv | 28 ++
 rtl/tp_counter.sv | 27 ++
 rtl/cntr_incr_arbiter.sv | 103 ++++++++++
 tb/tb_cntr_incr_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/agc_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | agc_timing_pkg                                                             |
// | Shared memory-cycle timing constants, FSM states and priority encoder.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package agc_timing_pkg;

  localparam int TP_N_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } arb_state_t;

  // Lowest set bit wins; an all-zero vector returns 0.
  function automatic int unsigned first_set_idx(input logic [31:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tp_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tp_counter                                                                 |
// | Free-running timepulse counter 1..TP_N, wrapping TP_N back to 1.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tp_counter #(
  parameter int TP_N = 12,
  parameter int TP_W = $clog2(TP_N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [TP_W-1:0] tp
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp <= TP_W'(1);
    end else if (tp == TP_W'(TP_N)) begin
      tp <= TP_W'(1);
    end else begin
      tp <= tp + TP_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cntr_incr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cntr_incr_arbiter                                                          |
// | Edge-detects scaler requests and grants one counter cycle per memory cycle.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cntr_incr_arbiter
  import agc_timing_pkg::*;
#(
  parameter int NREQ  = 6,
  parameter int TP_N  = TP_N_DEF,
  parameter int IDX_W = $clog2(NREQ),
  parameter int TP_W  = $clog2(TP_N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  stage_pulse,
  input  logic             inhibit,
  input  logic             inc_ack,
  output logic [TP_W-1:0]  tp,
  output logic             inc_req,
  output logic [IDX_W-1:0] inc_sel,
  output logic             inc_busy,
  output logic [NREQ-1:0]  pending,
  output logic             overflow_err
);

  arb_state_t      r_state;
  logic [NREQ-1:0] r_prev;
  logic [NREQ-1:0] w_set;
  logic [NREQ-1:0] w_clr;
  logic [NREQ-1:0] w_lost;
  logic            w_last_tp;
  logic            w_grant;

  tp_counter #(
    .TP_N (TP_N),
    .TP_W (TP_W)
  ) u_tp_counter (
    .clk (clk),
    .rst (rst),
    .tp  (tp)
  );

  assign w_last_tp = (tp == TP_W'(TP_N));
  assign w_grant   = (r_state == REQ) && w_last_tp && inc_ack;
  assign w_set     = stage_pulse & ~r_prev;
  assign w_clr     = w_grant ? (NREQ'(1) << inc_sel) : '0;
  // A re-arrival on a bit being cleared this cycle simply re-arms it.
  assign w_lost    = w_set & pending & ~w_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev       <= '0;
      pending      <= '0;
      overflow_err <= 1'b0;
    end else begin
      r_prev       <= stage_pulse;
      pending      <= (pending & ~w_clr) | w_set;
      overflow_err <= |w_lost;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      inc_req  <= 1'b0;
      inc_sel  <= '0;
      inc_busy <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|pending && !inhibit) begin
            r_state <= REQ;
            inc_req <= 1'b1;
            inc_sel <= IDX_W'(first_set_idx(32'(pending)));
          end
        end
        REQ: begin
          // inc_sel stays frozen; later, higher-priority arrivals wait.
          if (w_grant) begin
            r_state  <= SERVE;
            inc_req  <= 1'b0;
            inc_busy <= 1'b1;
          end
        end
        SERVE: begin
          if (w_last_tp) begin
            r_state  <= IDLE;
            inc_busy <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          inc_req  <= 1'b0;
          inc_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cntr_incr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cntr_incr_arbiter                                                       |
// | Directed self-checking bench for cntr_incr_arbiter.                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_cntr_incr_arbiter;

  localparam int NREQ  = 6;
  localparam int TP_N  = 12;
  localparam int IDX_W = 3;
  localparam int TP_W  = 4;

  logic             clk;
  logic             rst;
  logic [NREQ-1:0]  stage_pulse;
  logic             inhibit;
  logic             inc_ack;
  logic [TP_W-1:0]  tp;
  logic             inc_req;
  logic [IDX_W-1:0] inc_sel;
  logic             inc_busy;
  logic [NREQ-1:0]  pending;
  logic             overflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  cntr_incr_arbiter #(
    .NREQ  (NREQ),
    .TP_N  (TP_N),
    .IDX_W (IDX_W),
    .TP_W  (TP_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stage_pulse  (stage_pulse),
    .inhibit      (inhibit),
    .inc_ack      (inc_ack),
    .tp           (tp),
    .inc_req      (inc_req),
    .inc_sel      (inc_sel),
    .inc_busy     (inc_busy),
    .pending      (pending),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tp(input int n);
    int k;
    k = 0;
    while (tp != TP_W'(n) && k < 2 * TP_N) begin
      step();
      k++;
    end
    if (tp != TP_W'(n)) check_eq("wait_tp_timeout", 32'(tp), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tp"},       32'(tp), 1);
    check_eq({tag, "_pending"},  32'(pending), 0);
    check_eq({tag, "_inc_req"},  32'(inc_req), 0);
    check_eq({tag, "_inc_sel"},  32'(inc_sel), 0);
    check_eq({tag, "_inc_busy"}, 32'(inc_busy), 0);
    check_eq({tag, "_ovf"},      32'(overflow_err), 0);
  endtask

  initial begin
    int busy_cnt;
    int req_seen;

    rst         = 1'b1;
    stage_pulse = '0;
    inhibit     = 1'b0;
    inc_ack     = 1'b1;

    // Reset held for 2 cycles while the inputs toggle.
    #1;
    stage_pulse = 6'b111111;
    step();
    check_reset_outputs("rst_c1");
    stage_pulse = 6'b000000;
    step();
    check_reset_outputs("rst_c2");
    rst = 1'b0;

    // Single request on bit 3, rising during tp=5.
    wait_tp(5);
    stage_pulse = 6'b001000;
    step();
    check_eq("single_tp6", 32'(tp), 6);
    check_eq("single_pending", 32'(pending), 32'h08);
    check_eq("single_no_req_yet", 32'(inc_req), 0);
    stage_pulse = 6'b000000;
    step();
    check_eq("single_req_tp7", 32'(inc_req), 1);
    check_eq("single_sel_req", 32'(inc_sel), 3);
    wait_tp(12);
    check_eq("single_req_held", 32'(inc_req), 1);
    check_eq("single_not_busy", 32'(inc_busy), 0);
    step();
    check_eq("single_serve_tp1", 32'(tp), 1);
    check_eq("single_busy", 32'(inc_busy), 1);
    check_eq("single_req_drop", 32'(inc_req), 0);
    check_eq("single_sel_serve", 32'(inc_sel), 3);
    check_eq("single_cleared", 32'(pending), 0);
    busy_cnt = 0;
    for (int i = 0; i < TP_N + 1; i++) begin
      if (inc_busy) busy_cnt++;
      if (i < TP_N) step();
    end
    check_eq("single_busy_len", 32'(busy_cnt), 12);
    check_eq("single_idle_tp1", 32'(tp), 1);

    // Simultaneous rises on bits 4 and 1: bit 1 first.
    stage_pulse = 6'b010010;
    step();
    check_eq("prio_pending", 32'(pending), 32'h12);
    step();
    check_eq("prio_req1", 32'(inc_req), 1);
    check_eq("prio_sel1", 32'(inc_sel), 1);
    wait_tp(12);
    step();
    check_eq("prio_busy1", 32'(inc_busy), 1);
    check_eq("prio_pending_after1", 32'(pending), 32'h10);
    for (int i = 0; i < TP_N; i++) step();
    check_eq("prio_idle_gap", 32'(inc_req), 0);
    check_eq("prio_busy_end", 32'(inc_busy), 0);
    step();
    check_eq("prio_req2", 32'(inc_req), 1);
    check_eq("prio_sel2", 32'(inc_sel), 4);
    check_eq("prio_req2_tp", 32'(tp), 2);
    wait_tp(12);
    step();
    check_eq("prio_sel2_serve", 32'(inc_sel), 4);
    check_eq("prio_pending_after2", 32'(pending), 0);
    stage_pulse = 6'b000000;
    for (int i = 0; i < TP_N; i++) step();
    check_eq("prio_done_busy", 32'(inc_busy), 0);

    // Overflow on bit 2 while inhibited, then ack only at tp=12 counts.
    inhibit     = 1'b1;
    stage_pulse = 6'b000100;
    step();
    check_eq("ovf_pending1", 32'(pending), 32'h04);
    check_eq("ovf_none_first", 32'(overflow_err), 0);
    stage_pulse = 6'b000000;
    step();
    stage_pulse = 6'b000100;
    step();
    check_eq("ovf_pulse", 32'(overflow_err), 1);
    check_eq("ovf_pending2", 32'(pending), 32'h04);
    check_eq("ovf_inhibited", 32'(inc_req), 0);
    stage_pulse = 6'b000000;
    inc_ack     = 1'b0;
    inhibit     = 1'b0;
    step();
    check_eq("ovf_pulse_once", 32'(overflow_err), 0);
    check_eq("ovf_req", 32'(inc_req), 1);
    check_eq("ovf_sel", 32'(inc_sel), 2);
    wait_tp(7);
    inc_ack = 1'b1;
    step();
    inc_ack = 1'b0;
    check_eq("ack_tp7_ignored_busy", 32'(inc_busy), 0);
    check_eq("ack_tp7_ignored_req", 32'(inc_req), 1);
    wait_tp(12);
    inc_ack = 1'b1;
    step();
    check_eq("ack_tp12_busy", 32'(inc_busy), 1);
    check_eq("ack_tp12_pending", 32'(pending), 0);
    check_eq("ack_tp12_sel", 32'(inc_sel), 2);

    // New bit-0 request during SERVE, then async reset at tp=6.
    stage_pulse = 6'b000001;
    step();
    check_eq("midrst_pending", 32'(pending), 32'h01);
    stage_pulse = 6'b000000;
    wait_tp(6);
    check_eq("midrst_busy_before", 32'(inc_busy), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst_async");
    step();
    check_reset_outputs("midrst_held");
    rst = 1'b0;
    req_seen = 0;
    for (int i = 0; i < 2 * TP_N + 2; i++) begin
      step();
      if (inc_req || inc_busy || pending != 0) req_seen++;
    end
    check_eq("midrst_no_grant", 32'(req_seen), 0);
    stage_pulse = 6'b100000;
    step();
    check_eq("postrst_pending", 32'(pending), 32'h20);
    step();
    check_eq("postrst_req", 32'(inc_req), 1);
    check_eq("postrst_sel", 32'(inc_sel), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
